// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format codes, skid-buffer state type and datapath-width check
// used by the decode-stage immediate generator.
package riscv_imm_pkg;

  typedef logic [2:0] imm_src_t;

  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b010;
  localparam imm_src_t IMM_J = 3'b011;
  localparam imm_src_t IMM_U = 3'b100;
  localparam imm_src_t IMM_Z = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational RISC-V immediate extraction and extension to XLEN.
// instr carries instruction bits [31:7], so instruction bit k sits at instr[k-7].
module imm_extend_core
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_extend_core: XLEN must be 32 or 64");
  end

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign imm_i = instr[24:13];
  assign imm_s = {instr[24:18], instr[4:0]};
  assign imm_b = {instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
  assign imm_j = {instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
  assign imm_u = {instr[24:5], 12'b0};

  // Size casts of the signed fields perform the sign extension to XLEN.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   imm = XLEN'(imm_i);
      IMM_S:   imm = XLEN'(imm_s);
      IMM_B:   imm = XLEN'(imm_b);
      IMM_J:   imm = XLEN'(imm_j);
      IMM_U:   imm = XLEN'(imm_u);
      IMM_Z:   imm = XLEN'(instr[12:8]);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator behind a 2-entry skid buffer (main + skid)
// with valid/ready on both sides and synchronous flush.
module imm_extend_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  imm_src_t         imm_src,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  logic [XLEN-1:0]  core_imm;
  logic             core_ill;

  skid_state_e      state_q;
  logic [XLEN-1:0]  main_imm_q, skid_imm_q;
  logic [TAG_W-1:0] main_tag_q, skid_tag_q;
  logic             main_ill_q, skid_ill_q;
  logic             accept, pop;

  imm_extend_core #(.XLEN(XLEN)) u_core (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (core_imm),
    .illegal (core_ill)
  );

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm_ext = main_imm_q;
  assign out_tag = main_tag_q;
  assign illegal = main_ill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_ill_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_imm_q <= core_imm;
            main_tag_q <= in_tag;
            main_ill_q <= core_ill;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_imm_q <= core_imm;
            main_tag_q <= in_tag;
            main_ill_q <= core_ill;
          end else if (accept) begin
            skid_imm_q <= core_imm;
            skid_tag_q <= in_tag;
            skid_ill_q <= core_ill;
            state_q    <= ST_FULL;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (pop) begin
            main_imm_q <= skid_imm_q;
            main_tag_q <= skid_tag_q;
            main_ill_q <= skid_ill_q;
            state_q    <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe (XLEN 32 and 64 instances
// driven in parallel) against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [7:0]  in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [7:0]  tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } entry_t;

  entry_t     model_q[$];
  logic [7:0] popped[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32),
    .out_tag(tag32), .illegal(illegal32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm64),
    .out_tag(tag64), .illegal(illegal64)
  );

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] u, input int n);
    if (u[n-1]) return u - (64'd1 << n);
    return u;
  endfunction

  // Reference immediate from the full 32-bit instruction word.
  function automatic logic [63:0] ref_imm(input logic [24:0] ins, input logic [2:0] src);
    logic [31:0] w;
    w = {ins, 7'b0};
    case (src)
      3'd0:    return sext(64'(w[31:20]), 12);
      3'd1:    return sext(64'({w[31:25], w[11:7]}), 12);
      3'd2:    return sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      3'd3:    return sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      3'd4:    return sext(64'({w[31:12], 12'b0}), 32);
      3'd5:    return 64'(w[19:15]);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check_outputs();
    check_eq("out_valid32", 64'(out_valid32), 64'(model_q.size() > 0));
    check_eq("out_valid64", 64'(out_valid64), 64'(model_q.size() > 0));
    check_eq("in_ready32", 64'(in_ready32), 64'(model_q.size() < 2));
    check_eq("in_ready64", 64'(in_ready64), 64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      check_eq("imm32", 64'(imm32), 64'(model_q[0].imm[31:0]));
      check_eq("imm64", imm64, model_q[0].imm);
      check_eq("tag32", 64'(tag32), 64'(model_q[0].tag));
      check_eq("tag64", 64'(tag64), 64'(model_q[0].tag));
      check_eq("ill32", 64'(illegal32), 64'(model_q[0].ill));
      check_eq("ill64", 64'(illegal64), 64'(model_q[0].ill));
    end
  endtask

  // Called at a falling edge: check, drive, advance model, step one clock.
  task automatic cycle(input logic v, input logic [24:0] ins, input logic [2:0] src,
                       input logic [7:0] tg, input logic ordy, input logic fl);
    bit pop_m, acc_m;
    entry_t e;
    check_outputs();
    in_valid  = v;
    instr     = ins;
    imm_src   = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    if (out_valid32 && ordy && !fl) popped.push_back(tag32);
    pop_m = (model_q.size() > 0) && ordy;
    acc_m = v && (model_q.size() < 2);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_m) void'(model_q.pop_front());
      if (acc_m) begin
        e.imm = ref_imm(ins, src);
        e.tag = tg;
        e.ill = (src > 3'd5);
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_out_valid32", 64'(out_valid32), 64'd0);
    check_eq("rst_out_valid64", 64'(out_valid64), 64'd0);
    check_eq("rst_imm32", 64'(imm32), 64'd0);
    check_eq("rst_imm64", imm64, 64'd0);
    check_eq("rst_tag32", 64'(tag32), 64'd0);
    check_eq("rst_ill32", 64'(illegal32), 64'd0);
    check_eq("rst_in_ready32", 64'(in_ready32), 64'd1);
    check_eq("rst_in_ready64", 64'(in_ready64), 64'd1);
  endtask

  initial begin
    int tries;
    rst = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // I-type all ones, visible one cycle after accept
    cycle(1'b1, 25'h1FFFFFF, 3'd0, 8'd1, 1'b1, 1'b0);
    check_eq("I_imm32", 64'(imm32), 64'hFFFFFFFF);
    check_eq("I_valid", 64'(out_valid32), 64'd1);

    // S then B back to back
    cycle(1'b1, {7'h7F, 5'h00, 5'h00, 3'h0, 5'h04}, 3'd1, 8'd2, 1'b1, 1'b0);
    check_eq("S_imm32", 64'(imm32), 64'hFFFFFFE4);
    cycle(1'b1, 25'h1000001, 3'd2, 8'd3, 1'b1, 1'b0);
    check_eq("B_imm32", 64'(imm32), 64'hFFFFF800);
    check_eq("B_tag", 64'(tag32), 64'd3);

    // U, Z and reserved
    cycle(1'b1, {20'h12345, 5'h0}, 3'd4, 8'd4, 1'b1, 1'b0);
    check_eq("U_imm32", 64'(imm32), 64'h12345000);
    cycle(1'b1, {20'h80000, 5'h0}, 3'd4, 8'd5, 1'b1, 1'b0);
    check_eq("U_imm64", imm64, 64'hFFFFFFFF80000000);
    cycle(1'b1, 25'h001F00, 3'd5, 8'd6, 1'b1, 1'b0);
    check_eq("Z_imm32", 64'(imm32), 64'h0000001F);
    cycle(1'b1, 25'h1ABCDEF, 3'd6, 8'd7, 1'b1, 1'b0);
    check_eq("RSV_imm32", 64'(imm32), 64'd0);
    check_eq("RSV_ill", 64'(illegal32), 64'd1);

    // Backpressure: tags 1,2,3 with out_ready low for 3 cycles
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);
    popped.delete();
    cycle(1'b1, 25'h0123456, 3'd0, 8'd1, 1'b0, 1'b0);
    cycle(1'b1, 25'h0654321, 3'd1, 8'd2, 1'b0, 1'b0);
    check_eq("bp_in_ready_low", 64'(in_ready32), 64'd0);
    cycle(1'b1, 25'h1111111, 3'd3, 8'd3, 1'b0, 1'b0);
    check_eq("bp_still_full", 64'(in_ready32), 64'd0);
    tries = 0;
    while (!in_ready32 && tries < 10) begin
      cycle(1'b1, 25'h1111111, 3'd3, 8'd3, 1'b1, 1'b0);
      tries++;
    end
    check_eq("bp_ready_bound", 64'(in_ready32), 64'd1);
    cycle(1'b1, 25'h1111111, 3'd3, 8'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);
    check_eq("bp_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check_eq("bp_order", 64'(popped[i]), 64'(i + 1));

    // Flush while FULL with simultaneous in_valid, then while ONE with accept
    cycle(1'b1, 25'h0AAAAAA, 3'd0, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 25'h0BBBBBB, 3'd0, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 25'h0CCCCCC, 3'd0, 8'hAA, 1'b0, 1'b1);
    check_eq("fl_full_valid", 64'(out_valid32), 64'd0);
    check_eq("fl_full_ready", 64'(in_ready32), 64'd1);
    cycle(1'b1, 25'h0DDDDDD, 3'd0, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 25'h0EEEEEE, 3'd0, 8'hAB, 1'b1, 1'b1);
    check_eq("fl_one_valid", 64'(out_valid32), 64'd0);
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);
    check_eq("fl_no_leak", 64'(out_valid32), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 9) < 7), 25'($urandom), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

    // Asynchronous reset between clock edges while entries are held
    cycle(1'b1, 25'h1FFFFFF, 3'd0, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 25'h1FFFFFF, 3'd4, 8'h5B, 1'b0, 1'b0);
    check_outputs();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    model_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 25'($urandom), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, flow-controlled immediate generator for the decode stage. It generalises immediate extension to XLEN 32/64, adds U-type, CSR-uimm and reserved-encoding detection, and carries a pass-through tag. A 2-entry skid buffer with valid/ready handshakes on both sides sits between fetch/decode and execute, and it honours pipeline flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the pass-through tag (e.g. rd or ROB index); minimum 1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept this cycle.
- instr  in  25  instruction bits [31:7].
- imm_src  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR uimm), 110/111 reserved.
- in_tag  in  TAG_W  carried unchanged with the immediate.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  imm_ext/out_tag/illegal valid.
- out_ready  in  1  consumer accepts this cycle.
- imm_ext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the current output entry.
- illegal  out  1  imm_src was reserved for this entry.

## Operation
- Immediate extension is combinational on the input side. The result is captured on accept (in_valid && in_ready).
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U: sext({instr[31:12], 12'b0}) to XLEN; for XLEN=64, bits 63:32 replicate instr[31].
  - Z: zext(instr[19:15]).
  - Reserved: imm 0, illegal=1. All other codes: illegal=0.
- Storage is two entries, main (drives outputs) and skid, each holding {imm, tag, illegal, valid}.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- States: EMPTY (no entry valid), ONE (main valid), FULL (main and skid valid).
  - EMPTY + accept -> ONE.
  - ONE + accept + no pop -> FULL (new entry into skid).
  - ONE + accept + pop -> ONE (new entry into main).
  - ONE + pop only -> EMPTY.
  - FULL + pop -> ONE (skid moves to main). No accept is possible because in_ready=0.
- Pop = out_valid && out_ready. Ordering is strict FIFO; no entry is lost or duplicated.
- flush has priority over everything: next state EMPTY, and any same-cycle accept is discarded.
- When main is invalid, imm_ext, out_tag and illegal hold their last values; the consumer ignores them.

## Timing
- Latency is 1 cycle: a value accepted at edge N is on the outputs after edge N with out_valid=1.
- Throughput is 1/cycle while out_ready=1.
- Under reset: out_valid=0, imm_ext=0, out_tag=0, illegal=0, both valid bits 0, in_ready=1.
  - These values apply asynchronously on rst assertion, including mid-transfer.
  - Held entries are dropped.
- First accept is possible on the first rising edge after rst deasserts.
- flush asserted at edge N: out_valid=0 and in_ready=1 after edge N.
- out_ready low does not change outputs, except that a skid fill changes nothing visible.

## Structure
- Shared package riscv_imm_pkg holds:
  - IMM_I/IMM_S/IMM_B/IMM_J/IMM_U/IMM_Z localparams and the 3-bit imm_src type.
  - The XLEN legality check.
- Sub-module imm_extend_core (XLEN parameter) is purely combinational: instr, imm_src -> imm, illegal.
- imm_extend_pipe instantiates imm_extend_core plus the skid-buffer control.

## Test plan
- I-type, XLEN=32: instr=25'h1FFFFFF, src 000, out_ready=1 -> imm_ext=32'hFFFFFFFF, out_valid one cycle after accept.
- S then B, back-to-back, XLEN=32:
  - S: instr={7'h7F,5'h00,5'h00,5'h04} -> 32'hFFFFFFE4.
  - B: only instr[31] and instr[7] set -> 32'hFFFFF800.
  - Outputs appear on consecutive cycles.
- U and Z:
  - U, XLEN=32: instr[31:12]=20'h12345 -> 32'h12345000.
  - U, XLEN=64: instr[31:12]=20'h80000 -> 64'hFFFFFFFF80000000.
  - Z: instr[19:15]=5'h1F -> 32'h0000001F.
  - Reserved src 110 -> imm_ext=0, illegal=1.
- Backpressure: stream tags 1,2,3 with out_ready=0 for 3 cycles.
  - in_ready drops after tag 2 is accepted.
  - After out_ready=1, outputs are tags 1,2,3 in order, each exactly once.
- flush with FULL state plus simultaneous in_valid:
  - out_valid=0 and in_ready=1 next cycle.
  - Flushed entries and the same-cycle input never appear on the outputs.
- rst asserted mid-stream between clock edges: out_valid, imm_ext, out_tag and illegal go 0 immediately, without waiting for a clock edge.
